bus_timer: RTL

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer
// Purpose  : Bus-mapped down-counting timer (CTRL/LOAD/COUNT/STATUS) with
//            auto-reload, one-shot mode and W1C expiry interrupt.
//            Optional 16-bit prescaler enabled by macro TIMER_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timer (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_sel,
    input  logic        Bus_we,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic        timer_irq
);

    localparam logic [2:0] c_OFF_CTRL     = 3'd0;
    localparam logic [2:0] c_OFF_LOAD     = 3'd1;
    localparam logic [2:0] c_OFF_COUNT    = 3'd2;
    localparam logic [2:0] c_OFF_STATUS   = 3'd3;
    localparam logic [2:0] c_OFF_PRESCALE = 3'd4;

    logic [2:0]  ctrl_q,  ctrl_d;
    logic [31:0] load_q,  load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q,   exp_d;

    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_tick;
    logic        w_expire;
    logic        w_unused_addr;

    assign w_off         = Bus_addr[4:2];
    assign w_wr          = Bus_sel & Bus_we;
    assign w_unused_addr = &{1'b0, Bus_addr[31:5], Bus_addr[1:0]};

`ifdef TIMER_PRESCALE_EN
    logic [15:0] presc_q, presc_d;
    logic [15:0] pcnt_q,  pcnt_d;

    assign w_tick = ctrl_q[0] && (pcnt_q == presc_q);

    // Any CTRL write restarts the prescale phase so a fresh enable gets a full period.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q + 16'd1;
        if (!ctrl_q[0] || w_tick) begin
            pcnt_d = 16'd0;
        end
        if (w_wr && (w_off == c_OFF_CTRL)) begin
            pcnt_d = 16'd0;
        end
        if (w_wr && (w_off == c_OFF_PRESCALE)) begin
            presc_d = Bus_wdata[15:0];
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            presc_q <= 16'd0;
            pcnt_q  <= 16'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign w_tick = ctrl_q[0];
`endif

    assign w_expire = w_tick && (count_q == 32'd0);

    // Timer behaviour first; bus writes are applied afterwards so they take priority,
    // except W1C which must lose against a same-cycle expiry.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        if (w_tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                exp_d = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end
        if (w_wr) begin
            case (w_off)
                c_OFF_CTRL:   ctrl_d  = Bus_wdata[2:0];
                c_OFF_LOAD:   load_d  = Bus_wdata;
                c_OFF_COUNT:  count_d = Bus_wdata;
                c_OFF_STATUS: begin
                    if (Bus_wdata[0] && !w_expire) begin
                        exp_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ctrl_q  <= 3'd0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            exp_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        Bus_rdata = 32'd0;
        if (Bus_sel) begin
            case (w_off)
                c_OFF_CTRL:     Bus_rdata = {29'd0, ctrl_q};
                c_OFF_LOAD:     Bus_rdata = load_q;
                c_OFF_COUNT:    Bus_rdata = count_q;
                c_OFF_STATUS:   Bus_rdata = {31'd0, exp_q};
`ifdef TIMER_PRESCALE_EN
                c_OFF_PRESCALE: Bus_rdata = {16'd0, presc_q};
`endif
                default:        Bus_rdata = 32'd0;
            endcase
        end
    end

    assign timer_irq = exp_q & ctrl_q[2];

endmodule
`default_nettype wire
